unbiased_rounding_v2: RTL and testbench
=======================================

Name: unbiased_rounding_v2

Overview:
- Run-time-configurable convergent rounder (round-half-to-even) with saturation.
- Takes a `width_in`-bit value, signed or unsigned by parameter, held in the LSBs of a `WIDTH_IN_MAX`-bit bus.
- Drops the `width_in - WIDTH_OUT` LSBs, rounds, and saturates to `WIDTH_OUT` bits.
- Sits at the end of DSP datapaths to narrow accumulator/filter results without DC bias.

Parameters:
- `WIDTH_IN_MAX`, 32, width of the `din` bus; maximum supported input width.
- `WIDTH_OUT`, 16, output width; must be less than or equal to `WIDTH_IN_MAX`.
- `IS_SIGNED`, 1'b1, 1 = two's-complement input/output; 0 = unsigned.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `ena`  in  1  pipeline advance enable.
- `width_in`  in  `$clog2(WIDTH_IN_MAX+1)`  active input width; static per use.
- `din`  in  `WIDTH_IN_MAX`  input; only `din[width_in-1:0]` is significant.
- `dout`  out  `WIDTH_OUT`  rounded, saturated result (signed if `IS_SIGNED`).

Behaviour:
- Effective width `Wi = min(width_in, WIDTH_IN_MAX)`.
  - `Wi = 0` gives value 0.
  - Bits at index `Wi` and above are ignored.
- Value `x`:
  - `IS_SIGNED = 1`: `din[Wi-1:0]` is sign-extended from bit `Wi-1`.
  - `IS_SIGNED = 0`: zero-extended.
- Shift `D = Wi - WIDTH_OUT` if positive, else 0.
  - `D = 0`: no rounding; `x` passes through (sign/zero-extended to `WIDTH_OUT`).
- Rounding, for `D > 0`:
  - `q = x >>> D` (arithmetic shift, i.e. floor, in signed mode).
  - `f = x[D-1:0]`; `half = 1 << (D-1)`.
  - `q` becomes `q + 1` if `f > half`, or if `f == half` and `q[0] == 1`; otherwise `q` is kept.
  - Same rule for positive and negative values, so ties go to the even neighbour: -0.5 -> 0, -1.5 -> -2, 2.5 -> 2.
- Intermediate arithmetic is at least `WIDTH_IN_MAX + 1` bits so the `+1` never wraps.
- Saturation:
  - Signed: clamp to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1) - 1].
  - Unsigned: clamp to [0, 2^WIDTH_OUT - 1].
- Pipeline: 2 registered stages.
  - Stage 1 registers `q`, the round-up decision and the sign.
  - Stage 2 registers the incremented, saturated `dout`.
  - Latency: 2 `ena`-qualified clocks.
  - A `din` applied before edge N is visible on `dout` after edge N+1 when `ena = 1` throughout.
- `ena = 0`: all stages hold their contents; `dout` holds.
- `rst_n = 0` at a rising edge:
  - All pipeline registers clear and `dout = 0`, regardless of `ena`.
  - Reset mid-stream discards in-flight samples.
- Changing `width_in` mid-stream is permitted; it affects the sample entering stage 1 on that edge.
- Purely combinational datapath between registers; no state machine.

Optional Feature:
- Macro `UNBIASED_ROUNDING_SAT_FLAG_EN`.
- Defined:
  - Adds output port `sat` (1 bit), pipelined alongside `dout`.
  - `sat = 1` when that sample was clamped (post-rounding value outside the output range).
  - Reset value 0; held when `ena = 0`.
- Not defined: port absent; `dout` behaviour identical.

Test Plan:
All cases use `WIDTH_IN_MAX = 32`, `WIDTH_OUT = 16`, `width_in = 25` (D = 9, half = 0x100) unless stated, `ena = 1`, and check `dout` 2 clocks after `din`.
- Unsigned ties and rounding:
  - 0x100 -> 0; 0x300 -> 2; 0x500 -> 2; 0x501 -> 3; 0x2FF -> 1.
- Signed ties with 25-bit negative inputs:
  - 0x1FFFF00 (-0.5) -> 0x0000.
  - 0x1FFFD00 (-1.5) -> 0xFFFE.
  - 0x1FFFB00 (-2.5) -> 0xFFFE.
  - 0x1FFFE80 (-0.75) -> 0xFFFF.
- Saturation:
  - Unsigned 0x1FFFFFF -> 0xFFFF.
  - Signed 0x0FFFFFF -> 0x7FFF.
  - Signed 0x1000000 -> 0x8000 (exact, not clamped).
  - With `UNBIASED_ROUNDING_SAT_FLAG_EN`: `sat = 1` on the first two, 0 on the third.
- Width handling:
  - `width_in = 16`, `din` = 0xDEAD1234 -> 0x1234.
  - `width_in = 8` signed, `din` = 0x80 -> 0xFF80; unsigned -> 0x0080.
- Exhaustive sweep: all 2^25 values of `din[24:0]` in both modes match a golden model of the rule above.
- Control:
  - `ena = 0` for 5 clocks with `din` changing -> `dout` constant.
  - `rst_n = 0` for 1 edge mid-stream -> `dout = 0` on the next edge.
  - After release, the first valid result appears 2 clocks later.

Source files
------------

// File: rtl/unbiased_rounding_v2_if.sv
// Bus bundle for unbiased_rounding_v2: enable, active width, input sample and rounded result.
// The optional saturation flag exists only when UNBIASED_ROUNDING_SAT_FLAG_EN is defined.
interface unbiased_rounding_v2_if #(
    parameter int WIDTH_IN_MAX = 32,
    parameter int WIDTH_OUT    = 16
);
    localparam int WW = $clog2(WIDTH_IN_MAX + 1);

    // There is no valid/ready pair. ena is the only flow control: a sample is taken on
    // every rising edge with ena = 1. With ena = 0 every stage, and so dout, holds.
    logic                    ena;
    logic [WW-1:0]           width_in;
    logic [WIDTH_IN_MAX-1:0] din;
    logic [WIDTH_OUT-1:0]    dout;
`ifdef UNBIASED_ROUNDING_SAT_FLAG_EN
    logic                    sat;

    modport master (output ena, width_in, din, input dout, sat);
    modport slave  (input ena, width_in, din, output dout, sat);
`else
    modport master (output ena, width_in, din, input dout);
    modport slave  (input ena, width_in, din, output dout);
`endif
endinterface

// File: rtl/unbiased_rounding_v2.sv
// Two-stage convergent (round-half-to-even) rounder with saturation and run-time input width.
// Optional macro UNBIASED_ROUNDING_SAT_FLAG_EN adds a per-sample saturation flag (bus.sat).
module unbiased_rounding_v2 #(
    parameter int WIDTH_IN_MAX = 32,
    parameter int WIDTH_OUT    = 16,
    parameter bit IS_SIGNED    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unbiased_rounding_v2_if.slave bus
);
    localparam int WW = $clog2(WIDTH_IN_MAX + 1);
    localparam int XW = WIDTH_IN_MAX + 1;
    localparam int SW = XW + 1;
    localparam logic [WW-1:0] W_MAX = WW'(WIDTH_IN_MAX);
    localparam logic [WW-1:0] W_OUT = WW'(WIDTH_OUT);
    localparam logic signed [SW-1:0] OUT_MAX = IS_SIGNED ?
        SW'((64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1) : SW'((64'sd1 <<< WIDTH_OUT) - 64'sd1);
    localparam logic signed [SW-1:0] OUT_MIN = IS_SIGNED ?
        SW'(-(64'sd1 <<< (WIDTH_OUT - 1))) : SW'(0);

    logic [WW-1:0]          wi;
    logic [WW-1:0]          shift;
    logic                   ext;
    logic signed [XW-1:0]   x;
    logic signed [XW-1:0]   q_d;
    logic [XW-1:0]          guard_mask;
    logic [XW-1:0]          sticky_mask;
    logic                   guard;
    logic                   sticky;
    logic                   rnd_d;

    logic signed [XW-1:0]   q_q;
    logic                   rnd_q;
    logic                   sgn_q;

    logic signed [SW-1:0]   sum;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [WIDTH_OUT-1:0]   dout_d;
    logic [WIDTH_OUT-1:0]   dout_q;

    // Stage 1: normalise the active bits to an XW-bit value, then floor-shift.
    always_comb begin
        wi    = (bus.width_in > W_MAX) ? W_MAX : bus.width_in;
        shift = (wi > W_OUT) ? (wi - W_OUT) : '0;

        ext = 1'b0;
        for (int i = 0; i < WIDTH_IN_MAX; i++) begin
            if (IS_SIGNED && (WW'(i + 1) == wi)) begin
                ext = bus.din[i];
            end
        end

        x = '0;
        for (int i = 0; i < WIDTH_IN_MAX; i++) begin
            x[i] = (WW'(i) < wi) ? bus.din[i] : ext;
        end
        x[XW-1] = ext;

        q_d = x >>> shift;
    end

    // Guard is the dropped MSB (the half weight); sticky is any dropped bit below it.
    always_comb begin
        guard_mask  = (shift == '0) ? '0 : (XW'(1) << (shift - WW'(1)));
        sticky_mask = (shift == '0) ? '0 : (guard_mask - XW'(1));
        guard       = |(x & guard_mask);
        sticky      = |(x & sticky_mask);
        rnd_d       = guard & (sticky | q_d[0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= '0;
            rnd_q <= 1'b0;
            sgn_q <= 1'b0;
        end else if (bus.ena) begin
            q_q   <= q_d;
            rnd_q <= rnd_d;
            sgn_q <= x[XW-1];
        end
    end

    // Stage 2: increment with one bit of headroom, clamp toward the sign of the sample.
    always_comb begin
        sum    = {q_q[XW-1], q_q} + SW'(rnd_q);
        sat_hi = !sgn_q && (sum > OUT_MAX);
        sat_lo = sgn_q && (sum < OUT_MIN);
        if (sat_hi) begin
            dout_d = OUT_MAX[WIDTH_OUT-1:0];
        end else if (sat_lo) begin
            dout_d = OUT_MIN[WIDTH_OUT-1:0];
        end else begin
            dout_d = sum[WIDTH_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (bus.ena) begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

`ifdef UNBIASED_ROUNDING_SAT_FLAG_EN
    logic sat_d;
    logic sat_q;

    assign sat_d = sat_hi | sat_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (bus.ena) begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat = sat_q;
`endif
endmodule

// File: tb/tb_unbiased_rounding_v2.sv
// Bench for unbiased_rounding_v2: a signed and an unsigned instance share one stimulus stream.
module tb_unbiased_rounding_v2;
    localparam int WMAX = 32;
    localparam int WOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unbiased_rounding_v2_if #(.WIDTH_IN_MAX(WMAX), .WIDTH_OUT(WOUT)) bus_s ();
    unbiased_rounding_v2_if #(.WIDTH_IN_MAX(WMAX), .WIDTH_OUT(WOUT)) bus_u ();

    unbiased_rounding_v2 #(.WIDTH_IN_MAX(WMAX), .WIDTH_OUT(WOUT), .IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );
    unbiased_rounding_v2 #(.WIDTH_IN_MAX(WMAX), .WIDTH_OUT(WOUT), .IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bus_u)
    );

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_s_q[$];
    logic [16:0] exp_u_q[$];
    bit in_valid = 1'b0;
    bit s1_tok = 1'b0;
    bit out_tok = 1'b0;

    // Golden model: {sat, dout} computed with plain integer arithmetic.
    function automatic logic [16:0] model(input logic [31:0] din, input logic [5:0] w, input bit sgn);
        int wi;
        int d;
        longint x;
        longint q;
        longint f;
        longint half;
        longint mx;
        longint mn;
        logic sat;
        logic [15:0] r;
        wi = (int'(w) > 32) ? 32 : int'(w);
        x = 0;
        if (wi > 0) begin
            x = longint'({32'd0, din}) & ((64'sd1 <<< wi) - 64'sd1);
            if (sgn && (((x >>> (wi - 1)) & 64'sd1) == 64'sd1)) x = x - (64'sd1 <<< wi);
        end
        d = (wi > 16) ? wi - 16 : 0;
        q = x;
        if (d > 0) begin
            q = x >>> d;
            f = x - (q <<< d);
            half = 64'sd1 <<< (d - 1);
            if ((f > half) || ((f == half) && ((q & 64'sd1) == 64'sd1))) q = q + 64'sd1;
        end
        mx = sgn ? 64'sd32767 : 64'sd65535;
        mn = sgn ? -64'sd32768 : 64'sd0;
        sat = 1'b0;
        if (q > mx) begin
            q = mx;
            sat = 1'b1;
        end else if (q < mn) begin
            q = mn;
            sat = 1'b1;
        end
        r = q[15:0];
        return {sat, r};
    endfunction

    // Scoreboard: mirrors the two-stage occupancy and compares each emerging result.
    always begin
        logic [16:0] e_s;
        logic [16:0] e_u;
        @(posedge clk);
        if (!rst_n) begin
            s1_tok = 1'b0;
            out_tok = 1'b0;
            exp_s_q.delete();
            exp_u_q.delete();
        end else if (bus_s.ena) begin
            out_tok = s1_tok;
            s1_tok = in_valid;
        end else begin
            out_tok = 1'b0;
        end
        #2;
        if (out_tok) begin
            checks++;
            if (exp_s_q.size() == 0 || exp_u_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got output with %0d/%0d expected entries", exp_s_q.size(), exp_u_q.size());
            end else begin
                e_s = exp_s_q.pop_front();
                e_u = exp_u_q.pop_front();
                if (bus_s.dout !== e_s[15:0]) begin
                    errors++;
                    $display("FAIL signed_dout: got %h expected %h", bus_s.dout, e_s[15:0]);
                end
                checks++;
                if (bus_u.dout !== e_u[15:0]) begin
                    errors++;
                    $display("FAIL unsigned_dout: got %h expected %h", bus_u.dout, e_u[15:0]);
                end
`ifdef UNBIASED_ROUNDING_SAT_FLAG_EN
                checks += 2;
                if (bus_s.sat !== e_s[16]) begin
                    errors++;
                    $display("FAIL signed_sat: got %b expected %b", bus_s.sat, e_s[16]);
                end
                if (bus_u.sat !== e_u[16]) begin
                    errors++;
                    $display("FAIL unsigned_sat: got %b expected %b", bus_u.sat, e_u[16]);
                end
`endif
            end
        end
    end

    task automatic apply(input bit v, input logic [31:0] d, input logic [5:0] w, input bit en);
        @(negedge clk);
        bus_s.din = d;
        bus_u.din = d;
        bus_s.width_in = w;
        bus_u.width_in = w;
        bus_s.ena = en;
        bus_u.ena = en;
        in_valid = v;
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] w);
        apply(1'b1, d, w, 1'b1);
        exp_s_q.push_back(model(d, w, 1'b1));
        exp_u_q.push_back(model(d, w, 1'b0));
    endtask

    // Send with spec-given expectations; a mode without one falls back to the model.
    task automatic send_exp(input logic [31:0] d, input logic [5:0] w, input bit hs,
                            input logic [16:0] es, input bit hu, input logic [16:0] eu);
        apply(1'b1, d, w, 1'b1);
        exp_s_q.push_back(hs ? es : model(d, w, 1'b1));
        exp_u_q.push_back(hu ? eu : model(d, w, 1'b0));
    endtask

    task automatic test_reset();
        apply(1'b0, 32'hFFFF_FFFF, 6'd25, 1'b0);
        apply(1'b0, 32'h0123_4567, 6'd25, 1'b1);
        apply(1'b0, 32'h0000_0000, 6'd25, 1'b0);
        checks += 2;
        if (bus_s.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_signed: got %h expected 0000", bus_s.dout);
        end
        if (bus_u.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_unsigned: got %h expected 0000", bus_u.dout);
        end
`ifdef UNBIASED_ROUNDING_SAT_FLAG_EN
        checks++;
        if (bus_s.sat !== 1'b0 || bus_u.sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: got %b/%b expected 0/0", bus_s.sat, bus_u.sat);
        end
`endif
        rst_n = 1'b1;
        bus_s.ena = 1'b1;
        bus_u.ena = 1'b1;
    endtask

    task automatic test_ties_unsigned();
        send_exp(32'h100, 6'd25, 1'b1, 17'h0_0000, 1'b1, 17'h0_0000);
        send_exp(32'h300, 6'd25, 1'b1, 17'h0_0002, 1'b1, 17'h0_0002);
        send_exp(32'h500, 6'd25, 1'b1, 17'h0_0002, 1'b1, 17'h0_0002);
        send_exp(32'h501, 6'd25, 1'b1, 17'h0_0003, 1'b1, 17'h0_0003);
        send_exp(32'h2FF, 6'd25, 1'b1, 17'h0_0001, 1'b1, 17'h0_0001);
    endtask

    task automatic test_ties_signed();
        send_exp(32'h1FFFF00, 6'd25, 1'b1, 17'h0_0000, 1'b0, 17'h0);
        send_exp(32'h1FFFD00, 6'd25, 1'b1, 17'h0_FFFE, 1'b0, 17'h0);
        send_exp(32'h1FFFB00, 6'd25, 1'b1, 17'h0_FFFE, 1'b0, 17'h0);
        send_exp(32'h1FFFE80, 6'd25, 1'b1, 17'h0_FFFF, 1'b0, 17'h0);
    endtask

    task automatic test_saturation();
        send_exp(32'h1FFFFFF, 6'd25, 1'b0, 17'h0, 1'b1, 17'h1_FFFF);
        send_exp(32'h0FFFFFF, 6'd25, 1'b1, 17'h1_7FFF, 1'b0, 17'h0);
        send_exp(32'h1000000, 6'd25, 1'b1, 17'h0_8000, 1'b0, 17'h0);
        send_exp(32'h0FFFFFF, 6'd32, 1'b1, 17'h0_0100, 1'b1, 17'h0_0100);
    endtask

    task automatic test_width();
        send_exp(32'hDEAD1234, 6'd16, 1'b1, 17'h0_1234, 1'b1, 17'h0_1234);
        send_exp(32'h00000080, 6'd8, 1'b1, 17'h0_FF80, 1'b1, 17'h0_0080);
        send_exp(32'hFFFFFFFF, 6'd0, 1'b1, 17'h0_0000, 1'b1, 17'h0_0000);
        send_exp(32'h80000000, 6'd63, 1'b1, 17'h0_8000, 1'b1, 17'h0_8000);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [5:0] w;
        bit en;
        for (int i = 0; i < 1500; i++) begin
            d = $urandom;
            w = 6'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) d[8:0] = 9'h100;
            en = ($urandom_range(0, 7) != 0);
            apply(1'b1, d, w, en);
            if (en) begin
                exp_s_q.push_back(model(d, w, 1'b1));
                exp_u_q.push_back(model(d, w, 1'b0));
            end
        end
    endtask

    task automatic test_ena_hold();
        logic [15:0] hs;
        logic [15:0] hu;
        send(32'h0ABCDEF, 6'd25);
        send(32'h1234567, 6'd25);
        send(32'h1F00001, 6'd25);
        apply(1'b0, $urandom, 6'd25, 1'b0);
        hs = bus_s.dout;
        hu = bus_u.dout;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, $urandom, 6'($urandom_range(0, 40)), 1'b0);
            checks += 2;
            if (bus_s.dout !== hs) begin
                errors++;
                $display("FAIL ena_hold_signed: got %h expected %h", bus_s.dout, hs);
            end
            if (bus_u.dout !== hu) begin
                errors++;
                $display("FAIL ena_hold_unsigned: got %h expected %h", bus_u.dout, hu);
            end
        end
        send(32'h0000300, 6'd25);
        send(32'h1FFFD00, 6'd25);
    endtask

    task automatic test_reset_mid();
        send(32'h0FFFFFF, 6'd25);
        send(32'h1234567, 6'd25);
        send(32'h0ABCDEF, 6'd25);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        bus_s.din = 32'h0;
        bus_u.din = 32'h0;
        @(negedge clk);
        checks += 2;
        if (bus_s.dout !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_signed: got %h expected 0000", bus_s.dout);
        end
        if (bus_u.dout !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_unsigned: got %h expected 0000", bus_u.dout);
        end
        rst_n = 1'b1;
        bus_s.din = 32'h0000501;
        bus_u.din = 32'h0000501;
        in_valid = 1'b1;
        exp_s_q.push_back(model(32'h0000501, 6'd25, 1'b1));
        exp_u_q.push_back(model(32'h0000501, 6'd25, 1'b0));
        apply(1'b0, 32'h0, 6'd25, 1'b1);
        checks += 2;
        if (bus_s.dout !== 16'h0000) begin
            errors++;
            $display("FAIL release_latency_signed: got %h expected 0000", bus_s.dout);
        end
        if (bus_u.dout !== 16'h0000) begin
            errors++;
            $display("FAIL release_latency_unsigned: got %h expected 0000", bus_u.dout);
        end
    endtask

    initial begin
        bus_s.ena = 1'b0;
        bus_u.ena = 1'b0;
        bus_s.din = '0;
        bus_u.din = '0;
        bus_s.width_in = 6'd25;
        bus_u.width_in = 6'd25;
        test_reset();
        test_ties_unsigned();
        test_ties_signed();
        test_saturation();
        test_width();
        test_back_to_back();
        test_ena_hold();
        test_reset_mid();
        for (int i = 0; i < 4; i++) apply(1'b0, 32'h0, 6'd25, 1'b1);
        checks++;
        if (exp_s_q.size() != 0 || exp_u_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d leftover entries expected 0/0", exp_s_q.size(), exp_u_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
